// File: rtl/mem_access_unit.sv
// MEM-stage load/store unit: drives a valid/ready data bus, formats store lanes and load results.
// Optional misalignment trap is enabled with `define MISALIGN_TRAP_EN.
`ifndef LB
`define LB  3'd1
`define LBU 3'd2
`define LH  3'd3
`define LHU 3'd4
`define LW  3'd5
`endif
`ifndef SB
`define SB  2'd1
`define SH  2'd2
`define SW  2'd3
`endif

module mem_access_unit #(
    parameter int ADDR_W = 32,
    parameter int CNT_W  = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    input  logic [ADDR_W-1:0] addr,
    input  logic [31:0]       wdata,
    input  logic [2:0]        rd_ctrl,
    input  logic [1:0]        wr_ctrl,
    input  logic              mem_rw,
    output logic              stall,
    output logic [31:0]       rdata,
    output logic              rdata_valid,
    output logic              misalign_fault,
    output logic              bus_req_valid,
    input  logic              bus_req_ready,
    output logic [ADDR_W-1:0] bus_addr,
    output logic              bus_we,
    output logic [3:0]        bus_be,
    output logic [31:0]       bus_wdata,
    input  logic              bus_resp_valid,
    input  logic [31:0]       bus_resp_data,
    output logic [CNT_W-1:0]  stall_cnt,
    output logic [1:0]        dbg_state
);
    // Handshake: a request transfers on a cycle with bus_req_valid & bus_req_ready; the payload
    // is held stable while valid is high. bus_resp_valid is honoured only in RESP, one pulse per op.
    typedef enum logic [1:0] {IDLE = 2'd0, REQ = 2'd1, RESP = 2'd2, DONE = 2'd3} state_t;

    state_t            state_q, state_d;
    logic              start, misalign_c;
    logic [3:0]        be_c;
    logic [31:0]       wdata_c, load_c;
    logic [7:0]        byte_c;
    logic [15:0]       half_c;
    logic [1:0]        addr_lo_q;
    logic [2:0]        rd_ctrl_q;
    logic              load_q, fault_q;
    logic [ADDR_W-1:0] bus_addr_q;
    logic              bus_we_q;
    logic [3:0]        bus_be_q;
    logic [31:0]       bus_wdata_q, rdata_q;
    logic [CNT_W-1:0]  stall_cnt_q;

    assign start = req_valid & ((rd_ctrl != 3'd0) | mem_rw);

`ifdef MISALIGN_TRAP_EN
    always_comb begin
        misalign_c = 1'b0;
        if (mem_rw)
            misalign_c = ((wr_ctrl == `SH) & addr[0]) | ((wr_ctrl == `SW) & (addr[1:0] != 2'd0));
        else
            misalign_c = (((rd_ctrl == `LH) | (rd_ctrl == `LHU)) & addr[0]) |
                         ((rd_ctrl == `LW) & (addr[1:0] != 2'd0));
    end
`else
    assign misalign_c = 1'b0;
`endif

    // Store lane steering; a store always wins over a simultaneous load control.
    always_comb begin
        be_c    = 4'b1111;
        wdata_c = wdata;
        if (mem_rw) begin
            case (wr_ctrl)
                `SB: begin
                    be_c    = 4'b0001 << addr[1:0];
                    wdata_c = {4{wdata[7:0]}};
                end
                `SH: begin
                    be_c    = addr[1] ? 4'b1100 : 4'b0011;
                    wdata_c = {2{wdata[15:0]}};
                end
                `SW:     be_c = 4'b1111;
                default: be_c = 4'b0000;
            endcase
        end
    end

    always_comb begin
        state_d = state_q;
        stall   = 1'b0;
        case (state_q)
            IDLE: if (start) begin
                stall   = 1'b1;
                state_d = misalign_c ? DONE : REQ;
            end
            REQ: begin
                stall = 1'b1;
                if (bus_req_ready) state_d = RESP;
            end
            RESP: begin
                stall = 1'b1;
                if (bus_resp_valid) state_d = DONE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        case (addr_lo_q)
            2'd0:    byte_c = bus_resp_data[7:0];
            2'd1:    byte_c = bus_resp_data[15:8];
            2'd2:    byte_c = bus_resp_data[23:16];
            default: byte_c = bus_resp_data[31:24];
        endcase
        half_c = addr_lo_q[1] ? bus_resp_data[31:16] : bus_resp_data[15:0];
        case (rd_ctrl_q)
            `LB:     load_c = {{24{byte_c[7]}}, byte_c};
            `LBU:    load_c = {24'd0, byte_c};
            `LH:     load_c = {{16{half_c[15]}}, half_c};
            `LHU:    load_c = {16'd0, half_c};
            default: load_c = bus_resp_data;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            addr_lo_q   <= 2'd0;
            rd_ctrl_q   <= 3'd0;
            load_q      <= 1'b0;
            fault_q     <= 1'b0;
            bus_addr_q  <= '0;
            bus_we_q    <= 1'b0;
            bus_be_q    <= 4'd0;
            bus_wdata_q <= 32'd0;
            rdata_q     <= 32'd0;
            stall_cnt_q <= '0;
        end else begin
            state_q <= state_d;
            if (stall && (stall_cnt_q != {CNT_W{1'b1}}))
                stall_cnt_q <= stall_cnt_q + CNT_W'(1);
            if ((state_q == IDLE) && start) begin
                addr_lo_q   <= addr[1:0];
                rd_ctrl_q   <= rd_ctrl;
                load_q      <= ~mem_rw;
                fault_q     <= misalign_c;
                bus_addr_q  <= {addr[ADDR_W-1:2], 2'b00};
                bus_we_q    <= mem_rw;
                bus_be_q    <= be_c;
                bus_wdata_q <= wdata_c;
            end
            if ((state_q == RESP) && bus_resp_valid && load_q)
                rdata_q <= load_c;
        end
    end

    assign bus_req_valid  = (state_q == REQ);
    assign bus_addr       = bus_addr_q;
    assign bus_we         = bus_we_q;
    assign bus_be         = bus_be_q;
    assign bus_wdata      = bus_wdata_q;
    assign rdata          = rdata_q;
    assign rdata_valid    = (state_q == DONE) & load_q & ~fault_q;
    assign misalign_fault = (state_q == DONE) & fault_q;
    assign stall_cnt      = stall_cnt_q;
    assign dbg_state      = state_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit: scripted bus slave with programmable ready/response delay.
`ifndef LB
`define LB  3'd1
`define LBU 3'd2
`define LH  3'd3
`define LHU 3'd4
`define LW  3'd5
`endif
`ifndef SB
`define SB  2'd1
`define SH  2'd2
`define SW  2'd3
`endif

module tb_mem_access_unit;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req_valid = 1'b0;
    logic [31:0] addr = 32'd0;
    logic [31:0] wdata = 32'd0;
    logic [2:0]  rd_ctrl = 3'd0;
    logic [1:0]  wr_ctrl = 2'd0;
    logic        mem_rw = 1'b0;
    logic        stall, rdata_valid, misalign_fault, bus_req_valid, bus_we;
    logic [31:0] rdata, bus_addr, bus_wdata, stall_cnt;
    logic [3:0]  bus_be;
    logic        bus_req_ready = 1'b0;
    logic        bus_resp_valid = 1'b0;
    logic [31:0] bus_resp_data = 32'd0;
    logic [1:0]  dbg_state;

    int checks = 0;
    int errors = 0;
    logic [31:0] exp_q[$];

    logic [31:0] obs_addr, obs_wdata;
    logic [3:0]  obs_be;
    logic        obs_we, obs_stable, obs_done;
    int          obs_stalls, obs_rv, obs_flt, obs_req;

    mem_access_unit #(.ADDR_W(32), .CNT_W(32)) dut (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .addr(addr), .wdata(wdata),
        .rd_ctrl(rd_ctrl), .wr_ctrl(wr_ctrl), .mem_rw(mem_rw), .stall(stall),
        .rdata(rdata), .rdata_valid(rdata_valid), .misalign_fault(misalign_fault),
        .bus_req_valid(bus_req_valid), .bus_req_ready(bus_req_ready), .bus_addr(bus_addr),
        .bus_we(bus_we), .bus_be(bus_be), .bus_wdata(bus_wdata),
        .bus_resp_valid(bus_resp_valid), .bus_resp_data(bus_resp_data),
        .stall_cnt(stall_cnt), .dbg_state(dbg_state)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0; req_valid = 1'b0; bus_req_ready = 1'b0; bus_resp_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    // Runs one instruction: ready rises after rdy_dly low REQ cycles, response arrives
    // in the rsp_dly-th cycle after acceptance.
    task automatic do_op(input string tag, input logic [2:0] rd, input logic [1:0] wr,
                         input logic rw, input logic [31:0] a, input logic [31:0] wd,
                         input int rdy_dly, input int rsp_dly, input logic [31:0] rsp);
        int   rsp_cyc = 0;
        logic acc = 1'b0;
        obs_stalls = 0; obs_rv = 0; obs_flt = 0; obs_req = 0;
        obs_stable = 1'b1; obs_done = 1'b0;
        obs_addr = 32'd0; obs_wdata = 32'd0; obs_be = 4'd0; obs_we = 1'b0;
        @(negedge clk);
        req_valid = 1'b1; rd_ctrl = rd; wr_ctrl = wr; mem_rw = rw; addr = a; wdata = wd;
        for (int i = 0; i < 40 && !obs_done; i++) begin
            #1;
            if (rdata_valid) obs_rv++;
            if (misalign_fault) obs_flt++;
            bus_req_ready = 1'b0;
            bus_resp_valid = 1'b0;
            if (i > 0 && !stall) begin
                obs_done = 1'b1;
            end else begin
                if (stall) obs_stalls++;
                if (bus_req_valid) begin
                    if (obs_req == 0) begin
                        obs_addr = bus_addr; obs_wdata = bus_wdata; obs_be = bus_be; obs_we = bus_we;
                    end else if (bus_addr !== obs_addr || bus_wdata !== obs_wdata ||
                                 bus_be !== obs_be || bus_we !== obs_we) begin
                        obs_stable = 1'b0;
                    end
                    obs_req++;
                    bus_req_ready = (obs_req > rdy_dly);
                    acc = bus_req_ready;
                end else if (acc) begin
                    rsp_cyc++;
                    bus_resp_valid = (rsp_cyc >= rsp_dly);
                    bus_resp_data = bus_resp_valid ? rsp : 32'h0;
                end
                @(negedge clk);
            end
        end
        check({tag, "_done"}, {31'd0, obs_done}, 32'd1);
        // req_valid stays high through DONE; the following cycle must be IDLE, not a restart.
        @(negedge clk);
        req_valid = 1'b0;
        #1;
        if (rdata_valid) obs_rv++;
        check({tag, "_no_restart"}, {30'd0, dbg_state}, 32'd0);
    endtask

    initial begin
        do_reset();
        #1;
        check("rst_stall", {31'd0, stall}, 32'd0);
        check("rst_req_valid", {31'd0, bus_req_valid}, 32'd0);
        check("rst_rdata", rdata, 32'd0);
        check("rst_stall_cnt", stall_cnt, 32'd0);
        check("rst_state", {30'd0, dbg_state}, 32'd0);
        check("rst_be", {28'd0, bus_be}, 32'd0);

        do_op("sw", 3'd0, `SW, 1'b1, 32'h104, 32'hDEADBEEF, 0, 1, 32'h0);
        check("sw_addr", obs_addr, 32'h104);
        check("sw_we", {31'd0, obs_we}, 32'd1);
        check("sw_be", {28'd0, obs_be}, 32'hF);
        check("sw_wdata", obs_wdata, 32'hDEADBEEF);
        check("sw_stalls", obs_stalls, 32'd3);
        check("sw_stall_cnt", stall_cnt, 32'd3);
        check("sw_rv", obs_rv, 32'd0);

        do_op("sb", 3'd0, `SB, 1'b1, 32'h203, 32'h000000A5, 0, 1, 32'h0);
        check("sb_addr", obs_addr, 32'h200);
        check("sb_be", {28'd0, obs_be}, 32'h8);
        check("sb_wdata", obs_wdata, 32'hA5A5A5A5);

        exp_q.push_back(32'hFFFFFF80);
        do_op("lb", `LB, 2'd0, 1'b0, 32'h101, 32'h0, 0, 1, 32'h123480FF);
        check("lb_rdata", rdata, exp_q.pop_front());
        check("lb_we", {31'd0, obs_we}, 32'd0);
        check("lb_be", {28'd0, obs_be}, 32'hF);
        check("lb_rv", obs_rv, 32'd1);

        exp_q.push_back(32'h00000080);
        do_op("lbu", `LBU, 2'd0, 1'b0, 32'h101, 32'h0, 0, 1, 32'h123480FF);
        check("lbu_rdata", rdata, exp_q.pop_front());

        exp_q.push_back(32'hFFFF8001);
        do_op("lh", `LH, 2'd0, 1'b0, 32'h102, 32'h0, 0, 1, 32'h80017FFF);
        check("lh_rdata", rdata, exp_q.pop_front());
        check("lh_rv_pulse", obs_rv, 32'd1);

        exp_q.push_back(32'h00007FFF);
        do_op("lhu", `LHU, 2'd0, 1'b0, 32'h100, 32'h0, 0, 1, 32'h80017FFF);
        check("lhu_rdata", rdata, exp_q.pop_front());

        do_op("sh", 3'd0, `SH, 1'b1, 32'h102, 32'h1234ABCD, 0, 1, 32'h0);
        check("sh_be", {28'd0, obs_be}, 32'hC);
        check("sh_wdata", obs_wdata, 32'hABCDABCD);

        exp_q.push_back(32'hCAFEF00D);
        do_op("lw", `LW, 2'd0, 1'b0, 32'h108, 32'h0, 0, 1, 32'hCAFEF00D);
        check("lw_rdata", rdata, exp_q.pop_front());

        do_op("conflict", `LW, `SW, 1'b1, 32'h10C, 32'h11223344, 0, 1, 32'h99999999);
        check("conflict_we", {31'd0, obs_we}, 32'd1);
        check("conflict_wdata", obs_wdata, 32'h11223344);
        check("conflict_rdata_held", rdata, 32'hCAFEF00D);
        check("conflict_rv", obs_rv, 32'd0);

        do_reset();
        do_op("bp", 3'd0, `SW, 1'b1, 32'h300, 32'h55AA55AA, 4, 2, 32'h0);
        check("bp_stalls", obs_stalls, 32'd8);
        check("bp_stall_cnt", stall_cnt, 32'd8);
        check("bp_stable", {31'd0, obs_stable}, 32'd1);
        check("bp_req_cycles", obs_req, 32'd5);

        exp_q.push_back(32'hCAFEF00D);
        do_op("lw2", `LW, 2'd0, 1'b0, 32'h108, 32'h0, 0, 1, 32'hCAFEF00D);
        check("lw2_rdata", rdata, exp_q.pop_front());

        // Reset while waiting for the response, then a stray response in IDLE.
        @(negedge clk);
        req_valid = 1'b1; rd_ctrl = `LW; wr_ctrl = 2'd0; mem_rw = 1'b0; addr = 32'h100;
        bus_req_ready = 1'b1;
        @(negedge clk);
        @(negedge clk);
        #1;
        check("mid_state_resp", {30'd0, dbg_state}, 32'd2);
        rst_n = 1'b0; req_valid = 1'b0; bus_req_ready = 1'b0;
        @(negedge clk);
        rst_n = 1'b1; bus_resp_valid = 1'b1; bus_resp_data = 32'h77777777;
        #1;
        check("mid_rst_stall", {31'd0, stall}, 32'd0);
        check("mid_rst_rdata", rdata, 32'd0);
        check("mid_rst_cnt", stall_cnt, 32'd0);
        @(negedge clk);
        bus_resp_valid = 1'b0;
        #1;
        check("late_resp_state", {30'd0, dbg_state}, 32'd0);
        check("late_resp_rv", {31'd0, rdata_valid}, 32'd0);
        check("late_resp_rdata", rdata, 32'd0);

`ifdef MISALIGN_TRAP_EN
        do_op("mis", `LW, 2'd0, 1'b0, 32'h102, 32'h0, 0, 1, 32'h0BADF00D);
        check("mis_no_req", obs_req, 32'd0);
        check("mis_fault", obs_flt, 32'd1);
        check("mis_stalls", obs_stalls, 32'd1);
        check("mis_rv", obs_rv, 32'd0);
        check("mis_rdata", rdata, 32'd0);
`else
        do_op("mis", `LW, 2'd0, 1'b0, 32'h102, 32'h0, 0, 1, 32'h0BADF00D);
        check("mis_req", obs_req, 32'd1);
        check("mis_addr", obs_addr, 32'h100);
        check("mis_fault", obs_flt, 32'd0);
        check("mis_rdata", rdata, 32'h0BADF00D);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
